bus_slave_resp: RTL and testbench

BUS_SLAVE_RESP -- requirements
Module: bus_slave_resp

---
 rtl/bus_slave_resp_pkg.sv | 29 ++
 rtl/bus_slave_resp_mul32_seq.sv | 47 ++++
 rtl/bus_slave_resp.sv | 116 +++++++++++
 tb/tb_bus_slave_resp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_resp_pkg.sv
// Shared constants for the multiplier slave: register offsets, CTRL/STATUS bit positions
// and the FSM state encoding. Also used by bus-master code.
package bus_slave_resp_pkg;

   localparam logic [2:0] OffResultLo = 3'd0;
   localparam logic [2:0] OffResultHi = 3'd1;
   localparam logic [2:0] OffStatus   = 3'd2;
   localparam logic [2:0] OffOpcount  = 3'd3;
   localparam logic [2:0] OffOpa      = 3'd4;
   localparam logic [2:0] OffOpb      = 3'd5;
   localparam logic [2:0] OffCtrl     = 3'd6;

   localparam int unsigned CtrlStartBit   = 0;
   localparam int unsigned CtrlOpClearBit = 1;
   localparam int unsigned CtrlIntEnBit   = 2;

   localparam int unsigned StatBusyBit  = 0;
   localparam int unsigned StatDoneBit  = 1;
   localparam int unsigned StatIntEnBit = 2;

   localparam int unsigned NumIter = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StDone = 2'd2
   } state_t;

endpackage

// File: rtl/bus_slave_resp_mul32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier, one partial product per step.
module mul32_seq
   import bus_slave_resp_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        step,
   input  logic        clear,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [63:0] product,
   output logic        done
);

   logic [63:0] mcand_q;
   logic [31:0] mplier_q;
   logic [63:0] acc_q;
   logic [5:0]  iter_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         iter_q   <= '0;
      end else if (clear) begin
         acc_q  <= '0;
         iter_q <= '0;
      end else if (load) begin
         mcand_q  <= {32'h0, op_a};
         mplier_q <= op_b;
         acc_q    <= '0;
         iter_q   <= '0;
      end else if (step) begin
         acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 64'h0);
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         iter_q   <= iter_q + 6'd1;
      end
   end

   assign product = acc_q;
   // High during the final step so the owner can leave EXEC on the same edge it completes.
   assign done    = step && (iter_q == 6'(NumIter - 1));

endmodule

// File: rtl/bus_slave_resp.sv
// Memory-mapped slave that runs a sequential 32x32 multiply and raises a level interrupt
// when the 64-bit result is ready; reading OPCOUNT acknowledges it.
module bus_slave_resp
   import bus_slave_resp_pkg::*;
#(
   parameter logic [7:0] BASE = 8'h60
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        S_sel,
   input  logic        S_wr,
   input  logic [7:0]  S_address,
   input  logic [31:0] S_din,
   output logic [31:0] S_dout,
   output logic        m_interrupt
);

   state_t      state_q, state_d;
   logic [31:0] opa_q, opb_q;
   logic [7:0]  opcount_q;
   logic        int_en_q, ack_q;
   logic [7:0]  rel_addr;
   logic [2:0]  off;
   logic        in_win, rd_any, rd_hit, wr_hit, ctrl_wr;
   logic        start, op_clear, launch, mul_step, mul_done;
   logic        busy, done_st;
   logic [63:0] product;
   logic [31:0] status, rd_data;

   // Wrapping subtraction makes the window check a single upper-bits test.
   assign rel_addr = S_address - BASE;
   assign in_win   = (rel_addr[7:3] == 5'd0);
   assign off      = rel_addr[2:0];
   assign rd_any   = S_sel && !S_wr;
   assign rd_hit   = rd_any && in_win;
   assign wr_hit   = S_sel && S_wr && in_win;
   assign ctrl_wr  = wr_hit && (off == OffCtrl);
   assign start    = ctrl_wr && S_din[CtrlStartBit];
   assign op_clear = ctrl_wr && S_din[CtrlOpClearBit];
   assign launch   = start && !op_clear && (state_q != StExec);
   assign mul_step = (state_q == StExec) && !op_clear;

   mul32_seq u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (launch),
      .step    (mul_step),
      .clear   (op_clear),
      .op_a    (opa_q),
      .op_b    (opb_q),
      .product (product),
      .done    (mul_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (op_clear) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (start)    state_d = StExec;
            StExec:  if (mul_done) state_d = StDone;
            StDone:  if (start)    state_d = StExec;
            default:               state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy        = (state_q == StExec);
      done_st     = (state_q == StDone);
      m_interrupt = done_st && int_en_q && !ack_q;
   end

   always_comb begin
      status               = 32'h0;
      status[StatBusyBit]  = busy;
      status[StatDoneBit]  = done_st;
      status[StatIntEnBit] = int_en_q;
      case (off)
         OffResultLo: rd_data = product[31:0];
         OffResultHi: rd_data = product[63:32];
         OffStatus:   rd_data = status;
         OffOpcount:  rd_data = {24'h0, opcount_q};
         OffOpa:      rd_data = opa_q;
         OffOpb:      rd_data = opb_q;
         default:     rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         S_dout    <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         opcount_q <= '0;
         int_en_q  <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         if (rd_any) S_dout <= rd_hit ? rd_data : 32'h0;
         if (wr_hit && off == OffOpa) opa_q <= S_din;
         if (wr_hit && off == OffOpb) opb_q <= S_din;
         // A clear leaves the interrupt enable as it was.
         if (ctrl_wr && !op_clear) int_en_q <= S_din[CtrlIntEnBit];
         if (state_q == StExec && state_d == StDone) opcount_q <= opcount_q + 8'd1;
         if (op_clear || launch)            ack_q <= 1'b0;
         else if (rd_hit && off == OffOpcount) ack_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_slave_resp.sv
// Scoreboard bench for bus_slave_resp: reads push expected data, a monitor checks S_dout.
module tb_bus_slave_resp;

   localparam logic [7:0] Base = 8'h60;
   localparam logic [7:0] ALo = Base + 8'd0, AHi = Base + 8'd1, ASt = Base + 8'd2,
                          ACnt = Base + 8'd3, AOpa = Base + 8'd4, AOpb = Base + 8'd5,
                          ACtrl = Base + 8'd6, ARsv = Base + 8'd7;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        S_sel, S_wr;
   logic [7:0]  S_address;
   logic [31:0] S_din, S_dout;
   logic        m_interrupt;

   int   tests = 0;
   int   errors = 0;
   exp_t sb_q[$];

   bus_slave_resp #(.BASE(Base)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .S_sel       (S_sel),
      .S_wr        (S_wr),
      .S_address   (S_address),
      .S_din       (S_din),
      .S_dout      (S_dout),
      .m_interrupt (m_interrupt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every sampled read produces S_dout just after that edge.
   always @(posedge clk) begin
      if (reset_n && S_sel && !S_wr) begin
         exp_t e;
         #1;
         if (sb_q.size() == 0) begin
            chk("unexpected_read", S_dout, 32'h0);
         end else begin
            e = sb_q.pop_front();
            chk(e.name, S_dout, e.val);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
      @(negedge clk);
      S_sel = 1'b0; S_wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name;
      e.val  = exp;
      sb_q.push_back(e);
      S_sel = 1'b1; S_wr = 1'b0; S_address = a; S_din = 32'h0;
      @(negedge clk);
      S_sel = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_address = 8'h0; S_din = 32'h0;
      idle(2);
      chk("rst_dout", S_dout, 32'h0);
      chk("rst_irq", {31'h0, m_interrupt}, 32'h0);
      reset_n = 1'b1;
      idle(1);
      bus_rd(ASt, 32'h0, "rst_status");
      bus_rd(ACnt, 32'h0, "rst_opcount");

      // 7 x 6 with interrupt enabled
      bus_wr(AOpa, 32'd7);
      bus_wr(AOpb, 32'd6);
      bus_wr(ACtrl, 32'h5);
      idle(31);
      chk("irq_before_32", {31'h0, m_interrupt}, 32'h0);
      idle(1);
      chk("irq_at_32", {31'h0, m_interrupt}, 32'h1);
      bus_rd(ALo, 32'h2A, "s1_lo");
      bus_rd(AHi, 32'h0, "s1_hi");
      bus_rd(ASt, 32'h6, "s1_status");
      chk("irq_held_after_status", {31'h0, m_interrupt}, 32'h1);
      bus_rd(ACnt, 32'h1, "s1_opcount");
      chk("irq_acked", {31'h0, m_interrupt}, 32'h0);
      bus_rd(ALo, 32'h2A, "s1_lo_after_ack");

      // max operands, restart from DONE
      bus_wr(AOpa, 32'hFFFF_FFFF);
      bus_wr(AOpb, 32'hFFFF_FFFF);
      bus_wr(ACtrl, 32'h5);
      bus_rd(ASt, 32'h5, "s2_status_busy");
      idle(35);
      chk("s2_irq", {31'h0, m_interrupt}, 32'h1);
      bus_rd(AHi, 32'hFFFF_FFFE, "s2_hi");
      bus_rd(ALo, 32'h0000_0001, "s2_lo");
      bus_rd(ACnt, 32'h2, "s2_opcount");

      // op_clear at iteration 10
      bus_wr(AOpa, 32'd3);
      bus_wr(AOpb, 32'd5);
      bus_wr(ACtrl, 32'h5);
      idle(9);
      bus_wr(ACtrl, 32'h2);
      idle(40);
      chk("s3_irq", {31'h0, m_interrupt}, 32'h0);
      bus_rd(ALo, 32'h0, "s3_lo");
      bus_rd(AHi, 32'h0, "s3_hi");
      bus_rd(ACnt, 32'h2, "s3_opcount");
      bus_rd(AOpa, 32'd3, "s3_opa_kept");

      // interrupt disabled
      bus_wr(AOpa, 32'd9);
      bus_wr(AOpb, 32'd4);
      bus_wr(ACtrl, 32'h1);
      idle(40);
      chk("s4_irq", {31'h0, m_interrupt}, 32'h0);
      bus_rd(ASt, 32'h2, "s4_status");
      bus_rd(ALo, 32'h24, "s4_lo");

      // illegal writes and dead addresses
      bus_wr(ALo, 32'h1234);
      bus_wr(8'hE4, 32'hDEAD);
      bus_rd(ALo, 32'h24, "s5_lo_unchanged");
      bus_rd(ARsv, 32'h0, "s5_reserved");
      bus_rd(8'h05, 32'h0, "s5_out_of_window");
      bus_rd(ACtrl, 32'h0, "s5_ctrl_read");
      bus_rd(AOpa, 32'd9, "s5_opa_unchanged");

      // operand writes and start during EXEC are ignored by the running op
      bus_wr(AOpa, 32'd2);
      bus_wr(AOpb, 32'd3);
      bus_wr(ACtrl, 32'h1);
      idle(4);
      bus_wr(AOpa, 32'd100);
      bus_wr(ACtrl, 32'h1);
      idle(25);
      bus_rd(ASt, 32'h1, "s6_busy_at_32");
      bus_rd(ASt, 32'h2, "s6_done_at_33");
      bus_rd(ALo, 32'd6, "s6_lo");
      bus_rd(AOpa, 32'd100, "s6_opa_updated");
      bus_rd(ACnt, 32'h4, "s6_opcount");

      // reset mid-EXEC
      bus_wr(AOpa, 32'd11);
      bus_wr(AOpb, 32'd13);
      bus_wr(ACtrl, 32'h5);
      idle(10);
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_dout", S_dout, 32'h0);
      chk("async_rst_irq", {31'h0, m_interrupt}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(40);
      chk("post_rst_irq", {31'h0, m_interrupt}, 32'h0);
      bus_rd(ASt, 32'h0, "post_rst_status");
      bus_rd(ACnt, 32'h0, "post_rst_opcount");
      bus_rd(ALo, 32'h0, "post_rst_lo");
      bus_rd(AOpa, 32'h0, "post_rst_opa");

      // 256 back-to-back ops; last one gets a stray start mid-EXEC
      for (int i = 0; i < 256; i++) begin
         bus_wr(ACtrl, 32'h1);
         if (i == 255) begin
            idle(10);
            bus_wr(ACtrl, 32'h1);
            idle(21);
         end else begin
            idle(32);
         end
      end
      bus_rd(ASt, 32'h2, "s7_done_not_restarted");
      bus_rd(ACnt, 32'h0, "s7_opcount_wrap");
      chk("s7_irq", {31'h0, m_interrupt}, 32'h0);

      idle(3);
      chk("scoreboard_drained", sb_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
